// File: rtl/hex_tx_sequencer.sv
// Prints one NBYTES-wide binary word as uppercase ASCII hex, MS nibble first, optionally followed by CR LF.
// Latency: first character offered the cycle after an accepted start; done pulses one cycle after the last transfer.
// Backpressure: a character is held on tx_data with tx_valid high until tx_ready is seen; start is ignored while busy.
module hex_tx_sequencer #(
  parameter int NBYTES    = 2,
  parameter int SEND_CRLF = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   data,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  output logic                  busy,
  output logic                  done
);

  localparam int W      = 8 * NBYTES;
  localparam int NNIB   = 2 * NBYTES;
  localparam int LAST_I = (SEND_CRLF != 0) ? NNIB + 1 : NNIB - 1;
  localparam int IDX_W  = $clog2(NNIB + 2);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_I);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     word_q, word_d;
  logic             tx_valid_q;
  logic [7:0]       tx_data_q;
  logic             busy_q;
  logic             done_q;

  // Character at index i: hex digits first (MS nibble at index 0), then CR and LF.
  function automatic logic [7:0] char_at(input logic [W-1:0] w, input logic [IDX_W-1:0] i);
    logic [3:0] nib;
    int         k;
    k   = int'(i);
    nib = 4'd0;
    if (k < NNIB) begin
      nib = 4'(w >> (4 * (NNIB - 1 - k)));
      if (nib < 4'd10) char_at = 8'd48 + {4'd0, nib};
      else             char_at = 8'd55 + {4'd0, nib};
    end else if (k == NNIB) begin
      char_at = 8'h0D;
    end else begin
      char_at = 8'h0A;
    end
  endfunction

  // Next-state logic: capture on start in IDLE, advance index only on a transfer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          word_d  = data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q == LAST) state_d = DONE;
          else               idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs are precomputed from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      word_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      tx_valid_q <= (state_d == SEND);
      tx_data_q  <= (state_d == SEND) ? char_at(word_d, idx_d) : 8'h00;
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_hex_tx_sequencer.sv
module tb_hex_tx_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;

  logic        start1;
  logic [7:0]  data1;
  logic        tx_ready1;
  logic        tx_valid1;
  logic [7:0]  tx_data1;
  logic        busy1;
  logic        done1;

  int n_total;
  int n_pass;

  hex_tx_sequencer #(.NBYTES(2), .SEND_CRLF(1)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data     (data),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done)
  );

  hex_tx_sequencer #(.NBYTES(1), .SEND_CRLF(0)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start1),
    .data     (data1),
    .tx_ready (tx_ready1),
    .tx_valid (tx_valid1),
    .tx_data  (tx_data1),
    .busy     (busy1),
    .done     (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [31:0] hex;   // four expected ASCII chars, first char in the top byte
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Sends one word starting from an IDLE cycle; ends in the IDLE cycle after DONE.
  task automatic send_word(input logic [15:0] d, input logic [31:0] hex, input int stall,
                           input bit inject, input string tag);
    logic [7:0] want;
    int         xfers;
    xfers = 0;
    chk({tag, ":idle_busy"}, 32'(busy), 32'd0);
    start    = 1'b1;
    data     = d;
    tx_ready = (stall == 0);
    step();
    start = 1'b0;
    data  = 16'($urandom);
    for (int k = 0; k < 6; k++) begin
      if (k < 4)       want = hex[31-8*k -: 8];
      else if (k == 4) want = 8'h0D;
      else             want = 8'h0A;
      for (int s = 0; s < stall; s++) begin
        tx_ready = 1'b0;
        chk($sformatf("%s:stall_vld%0d_%0d", tag, k, s), 32'(tx_valid), 32'd1);
        chk($sformatf("%s:stall_dat%0d_%0d", tag, k, s), 32'(tx_data), 32'(want));
        step();
        data = 16'($urandom);
      end
      tx_ready = 1'b1;
      chk($sformatf("%s:vld%0d", tag, k), 32'(tx_valid), 32'd1);
      chk($sformatf("%s:dat%0d", tag, k), 32'(tx_data), 32'(want));
      chk($sformatf("%s:busy%0d", tag, k), 32'(busy), 32'd1);
      chk($sformatf("%s:nodone%0d", tag, k), 32'(done), 32'd0);
      if (tx_valid && tx_ready) xfers++;
      if (inject && k == 1) begin
        start = 1'b1;
        data  = 16'hFFFF;
      end
      step();
      start = 1'b0;
      data  = 16'($urandom);
    end
    chk({tag, ":done"}, 32'(done), 32'd1);
    chk({tag, ":done_vld"}, 32'(tx_valid), 32'd0);
    chk({tag, ":done_dat"}, 32'(tx_data), 32'd0);
    chk({tag, ":done_busy"}, 32'(busy), 32'd1);
    chk({tag, ":xfers"}, 32'(xfers), 32'd6);
    step();
    chk({tag, ":done_pulse"}, 32'(done), 32'd0);
    chk({tag, ":idle_vld"}, 32'(tx_valid), 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    vecs[0] = '{16'h1A2F, 32'h31413246};
    vecs[1] = '{16'h09AF, 32'h30394146};
    vecs[2] = '{16'h0000, 32'h30303030};
    vecs[3] = '{16'hFFFF, 32'h46464646};
    vecs[4] = '{16'hBEEF, 32'h42454546};
    vecs[5] = '{16'h1234, 32'h31323334};
    vecs[6] = '{16'hC0DE, 32'h43304445};
    vecs[7] = '{16'h5A79, 32'h35413739};

    rst = 1'b1; start = 1'b0; data = 16'h0; tx_ready = 1'b0;
    start1 = 1'b0; data1 = 8'h0; tx_ready1 = 1'b0;
    step();
    start = 1'b1; data = 16'h1234; tx_ready = 1'b1;
    step();
    chk("rst_vld", 32'(tx_valid), 32'd0);
    chk("rst_dat", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst1_vld", 32'(tx_valid1), 32'd0);
    chk("rst1_busy", 32'(busy1), 32'd0);
    rst = 1'b0; start = 1'b0; tx_ready = 1'b0;
    step();
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Back-to-back words, each started in the IDLE cycle right after DONE.
    for (int i = 0; i < 8; i++)
      send_word(vecs[i].d, vecs[i].hex, 0, 1'b0, $sformatf("vec%0d", i));

    // Three stall cycles before every transfer.
    send_word(16'h09AF, 32'h30394146, 3, 1'b0, "stall");

    // Start during SEND is ignored and not queued.
    send_word(16'h0000, 32'h30303030, 0, 1'b1, "inject");
    step();
    chk("not_queued_busy", 32'(busy), 32'd0);
    chk("not_queued_vld", 32'(tx_valid), 32'd0);

    // Reset in mid-word abandons it.
    start = 1'b1; data = 16'h1234; tx_ready = 1'b1;
    step();
    start = 1'b0;
    chk("rstmid_c0", 32'(tx_data), 32'h31);
    step();
    chk("rstmid_c1", 32'(tx_data), 32'h32);
    step();
    chk("rstmid_c2", 32'(tx_data), 32'h33);
    rst = 1'b1; start = 1'b1;
    step();
    chk("rstmid_vld", 32'(tx_valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_dat", 32'(tx_data), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("rstmid_quiet_done%0d", c), 32'(done), 32'd0);
      chk($sformatf("rstmid_quiet_vld%0d", c), 32'(tx_valid), 32'd0);
    end
    send_word(16'hBEEF, 32'h42454546, 0, 1'b0, "after_rst");

    // Single-byte instance without CR/LF.
    start1 = 1'b1; data1 = 8'hC3; tx_ready1 = 1'b1;
    step();
    start1 = 1'b0; data1 = 8'h00;
    chk("nb1_c0_vld", 32'(tx_valid1), 32'd1);
    chk("nb1_c0", 32'(tx_data1), 32'h43);
    step();
    chk("nb1_c1", 32'(tx_data1), 32'h33);
    chk("nb1_c1_done", 32'(done1), 32'd0);
    step();
    chk("nb1_done", 32'(done1), 32'd1);
    chk("nb1_done_vld", 32'(tx_valid1), 32'd0);
    step();
    chk("nb1_idle_done", 32'(done1), 32'd0);
    chk("nb1_idle_busy", 32'(busy1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hex_tx_sequencer.md
HEX_TX_SEQUENCER -- requirements
Module: hex_tx_sequencer

Interface
REQ-001 Parameter NBYTES, default 2: number of bytes in the input word; word width is 8*NBYTES and nibble count is 2*NBYTES.
REQ-002 Parameter SEND_CRLF, default 1: when 1, append 8'h0D then 8'h0A after the last hex character; when 0, append nothing.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to print one word; sampled only in IDLE.
REQ-006 data  input  8*NBYTES  binary word to print; captured on an accepted start.
REQ-007 tx_ready  input  1  downstream (UART TX) can accept a byte this cycle.
REQ-008 tx_valid  output  1  tx_data holds a valid character.
REQ-009 tx_data  output  8  ASCII character being offered.
REQ-010 busy  output  1  high from the cycle after an accepted start until the return to IDLE.
REQ-011 done  output  1  single-cycle pulse after the final character is transferred.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SEND and DONE.
REQ-013 In IDLE with start=1, the block SHALL register data into an internal word, clear the character index to 0 and enter SEND on the next edge.
REQ-014 start SHALL be ignored in SEND and DONE; the captured word SHALL NOT change while busy, even if data changes.
REQ-015 In SEND, tx_valid SHALL be 1 and tx_data SHALL be the character at the current index; the index runs 0..2*NBYTES-1 for hex characters, then 2*NBYTES and 2*NBYTES+1 for CR and LF when SEND_CRLF=1.
REQ-016 Hex characters SHALL be emitted most-significant nibble first.
REQ-017 Each nibble n SHALL map to 8'd48+n for n in 0..9 and to 8'd55+n for n in 10..15, giving uppercase 'A'..'F'.
REQ-018 A transfer occurs on a cycle where tx_valid=1 and tx_ready=1; only then SHALL the index advance by one.
REQ-019 While tx_ready=0 in SEND, tx_valid and tx_data SHALL hold their values unchanged for any number of cycles.
REQ-020 A transfer at the last index (2*NBYTES-1 if SEND_CRLF=0, otherwise 2*NBYTES+1) SHALL move the FSM to DONE instead of advancing the index.
REQ-021 In DONE, done SHALL be 1 and tx_valid 0 for exactly one cycle; the FSM SHALL then return to IDLE unconditionally.
REQ-022 busy SHALL be 1 in SEND and DONE and 0 in IDLE.
REQ-023 Latency: for an accepted start at cycle 0, the first character SHALL appear with tx_valid=1 at cycle 1; with tx_ready held at 1, done SHALL pulse at cycle N+1, where N is the total character count (6 for the defaults).
REQ-024 Minimum restart spacing: a start in the IDLE cycle after DONE SHALL be accepted, giving back-to-back words with one idle cycle.
REQ-025 tx_data SHALL be 8'h00 whenever tx_valid=0.
REQ-026 All outputs SHALL be registered or decoded only from the state, the index and the captured word, with no combinational path from tx_ready or start to any output.

Reset
REQ-027 When rst=1 at a clock edge, the FSM SHALL enter IDLE, and the index and captured word SHALL clear to 0.
REQ-028 While reset is applied, tx_valid, tx_data, busy and done SHALL all read 0, and reset SHALL take priority over start and tx_ready.
REQ-029 A reset during SEND SHALL abandon the word immediately, with no further characters and no done pulse.

Verification
REQ-030 data=16'h1A2F, start pulse, tx_ready=1 constantly -> tx_data sequence 8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A on consecutive cycles 1..6, and done=1 at cycle 7 only.
REQ-031 data=16'h09AF, tx_ready low for 3 cycles before each transfer -> sequence 8'h30, 8'h39, 8'h41, 8'h46, 8'h0D, 8'h0A with each byte held stable throughout its stall, and exactly six transfers.
REQ-032 Start pulse with data=16'hFFFF during SEND of 16'h0000 -> output is 8'h30 x4 plus CR/LF only, and the second start is not queued.
REQ-033 rst asserted after the second transfer of 16'h1234 -> next cycle tx_valid=0, busy=0, done never pulses; a subsequent start with 16'hBEEF yields 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A.
REQ-034 Instantiate with SEND_CRLF=0 and NBYTES=1, data=8'hC3 -> sequence 8'h43, 8'h33, then done at cycle 3.
REQ-035 Start asserted in the IDLE cycle immediately after DONE -> accepted, and the new word begins at the following cycle.
